// File: rtl/fetch_pc_unit.sv
// Fetch / PC unit: three-state fetch handshake, issue hold, and next-PC
// resolution with branch compare, JAL/JALR targets and misalignment trap.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic [31:0] link_pc,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic        is_jalr,
  input  logic [2:0]  branch_type,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {StFetch, StWait, StIssue} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        trap_q, trap_d;

  logic        br_taken;
  logic        take;
  logic        misaligned;
  logic [31:0] target;
  logic [31:0] next_pc;

  // Branch condition decode on funct3; 010/011 are never taken.
  always_comb begin
    br_taken = 1'b0;
    case (branch_type)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data < rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Next-PC select: jump beats branch; a misaligned taken target redirects to the trap vector.
  always_comb begin
    if (jump && is_jalr) begin
      target = (rs1_data + imm) & 32'hFFFF_FFFE;
    end else begin
      target = pc_q + imm;
    end
    take       = jump | (branch & br_taken);
    misaligned = take && (target[1:0] != 2'b00);
    if (!take) begin
      next_pc = pc_q + 32'd4;
    end else if (misaligned) begin
      next_pc = TRAP_VEC;
    end else begin
      next_pc = target;
    end
  end

  // FSM next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    trap_d    = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (imem_gnt) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid) begin
          instr_d = imem_rdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (resolve_valid) begin
          pc_d      = next_pc;
          retired_d = retired_q + 32'd1;
          trap_d    = misaligned;
          state_d   = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0;
      retired_q <= 32'h0;
      trap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      trap_q    <= trap_d;
    end
  end

  // Request is gated by reset so it only rises once reset is released.
  assign imem_req    = (state_q == StFetch) && rst_n;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StIssue);
  assign instr       = instr_q;
  assign pc_out      = pc_q;
  assign link_pc     = pc_q + 32'd4;
  assign trap        = trap_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic [31:0] link_pc;
  logic        resolve_valid;
  logic        branch;
  logic        jump;
  logic        is_jalr;
  logic [2:0]  branch_type;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        trap;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  fetch_pc_unit #(
    .RESET_PC(32'h0000_0000),
    .TRAP_VEC(32'h0000_0010)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .pc_out       (pc_out),
    .link_pc      (link_pc),
    .resolve_valid(resolve_valid),
    .branch       (branch),
    .jump         (jump),
    .is_jalr      (is_jalr),
    .branch_type  (branch_type),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .trap         (trap),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: grant and respond immediately, leaving the unit in ISSUE.
  task automatic to_issue(input logic [31:0] word);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    tick();
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  // One resolve cycle in ISSUE with the given control-flow inputs.
  task automatic resolve_with(input logic br, input logic jmp, input logic jalr,
                              input logic [2:0] bt, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] im);
    branch        = br;
    jump          = jmp;
    is_jalr       = jalr;
    branch_type   = bt;
    rs1_data      = a;
    rs2_data      = b;
    imm           = im;
    resolve_valid = 1'b1;
    tick();
    resolve_valid = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    is_jalr       = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    resolve_valid = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    is_jalr       = 1'b0;
    branch_type   = 3'b000;
    rs1_data      = 32'h0;
    rs2_data      = 32'h0;
    imm           = 32'h0;
    #12;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_trap", {31'h0, trap}, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);

    // Basic fetch/issue/resolve with everything ready at once.
    #1 rst_n = 1'b1;
    #1;
    chk("rel_req", {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr, 32'h0);
    imem_gnt      = 1'b1;
    imem_rvalid   = 1'b1;
    imem_rdata    = 32'h0050_0093;
    resolve_valid = 1'b1;
    tick();
    chk("wait_req", {31'h0, imem_req}, 32'h0);
    chk("wait_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("iss_valid", {31'h0, instr_valid}, 32'h1);
    chk("iss_instr", instr, 32'h0050_0093);
    chk("iss_pc", pc_out, 32'h0);
    chk("iss_link", link_pc, 32'h4);
    tick();
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    resolve_valid = 1'b0;
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_retired", retired, 32'h1);
    chk("seq_req", {31'h0, imem_req}, 32'h1);

    // JAL to 0x20, then BEQ taken backwards.
    to_issue(32'h01C0_006F);
    resolve_with(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h1C);
    chk("jal_addr", imem_addr, 32'h20);
    to_issue(32'hFE73_0CE3);
    resolve_with(1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd7, 32'hFFFF_FFF8);
    chk("beq_taken", imem_addr, 32'h18);
    to_issue(32'h0080_006F);
    resolve_with(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h8);
    chk("jal2_addr", imem_addr, 32'h20);
    to_issue(32'hFE83_0CE3);
    resolve_with(1'b1, 1'b0, 1'b0, 3'b000, 32'd7, 32'd8, 32'hFFFF_FFF8);
    chk("beq_not", imem_addr, 32'h24);

    // Unsigned vs signed compare of 1 against all-ones.
    to_issue(32'h0);
    resolve_with(1'b1, 1'b0, 1'b0, 3'b110, 32'd1, 32'hFFFF_FFFF, 32'h10);
    chk("bltu_taken", imem_addr, 32'h34);
    to_issue(32'h0);
    resolve_with(1'b1, 1'b0, 1'b0, 3'b100, 32'd1, 32'hFFFF_FFFF, 32'h10);
    chk("blt_not", imem_addr, 32'h38);
    to_issue(32'h0);
    resolve_with(1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h8);
    chk("jal3_addr", imem_addr, 32'h40);

    // JALR to a misaligned target traps.
    to_issue(32'h0020_8067);
    chk("jalr_link", link_pc, 32'h44);
    chk("jalr_pc", pc_out, 32'h40);
    resolve_with(1'b0, 1'b1, 1'b1, 3'b000, 32'h101, 32'h0, 32'h2);
    chk("trap_pulse", {31'h0, trap}, 32'h1);
    chk("trap_addr", imem_addr, 32'h10);
    chk("trap_retired", retired, 32'd9);
    tick();
    chk("trap_clear", {31'h0, trap}, 32'h0);

    // Jump wins over a not-taken branch; funct3 010 never branches.
    to_issue(32'h0);
    resolve_with(1'b1, 1'b1, 1'b0, 3'b001, 32'd5, 32'd5, 32'h20);
    chk("prio_jump", imem_addr, 32'h30);
    to_issue(32'h0);
    resolve_with(1'b1, 1'b0, 1'b0, 3'b010, 32'd5, 32'd5, 32'h8);
    chk("bt010_not", imem_addr, 32'h34);
    chk("retired11", retired, 32'd11);

    // Slow grant and slow response; resolve outside ISSUE is ignored.
    resolve_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("gnt_wait_addr", imem_addr, 32'h34);
      chk("gnt_wait_req", {31'h0, imem_req}, 32'h1);
    end
    chk("gnt_wait_ret", retired, 32'd11);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rv_wait_valid", {31'h0, instr_valid}, 32'h0);
      chk("rv_wait_addr", imem_addr, 32'h34);
    end
    resolve_valid = 1'b0;
    imem_rvalid   = 1'b1;
    imem_rdata    = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h1234_5678;
    chk("slow_valid", {31'h0, instr_valid}, 32'h1);
    chk("slow_instr", instr, 32'hDEAD_BEEF);
    tick();
    chk("hold_valid", {31'h0, instr_valid}, 32'h1);
    chk("hold_instr", instr, 32'hDEAD_BEEF);
    resolve_with(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("slow_next", imem_addr, 32'h38);
    chk("retired12", retired, 32'd12);

    // Reset in WAIT drops the pending response.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", imem_addr, 32'h0);
    chk("mid_rst_ret", retired, 32'h0);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    #3 rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    tick();
    tick();
    imem_rvalid = 1'b0;
    chk("stale_valid", {31'h0, instr_valid}, 32'h0);
    chk("stale_req", {31'h0, imem_req}, 32'h1);
    chk("stale_addr", imem_addr, 32'h0);
    chk("stale_instr", instr, 32'h0);
    to_issue(32'h0050_0093);
    chk("restart_pc", pc_out, 32'h0);
    resolve_with(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0);
    chk("restart_addr", imem_addr, 32'h4);
    chk("restart_ret", retired, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
